// File: rtl/mc_seq_ctrl.sv
// mc_seq_ctrl: multi-cycle miniRV sequencer driving PC, IR, memories and write-back
module mc_seq_ctrl #(
    parameter int BOOT_HOLD = 1,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             br_taken,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             halt_req,
    output logic             pc_en,
    output logic [1:0]       npc_sel,
    output logic             ir_en,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired,
    output logic             halted
);
    localparam int HOLD = (BOOT_HOLD < 1) ? 1 : BOOT_HOLD;
    localparam logic [2:0] S_BOOT = 3'd0;
    localparam logic [2:0] S_IF   = 3'd1;
    localparam logic [2:0] S_ID   = 3'd2;
    localparam logic [2:0] S_EX   = 3'd3;
    localparam logic [2:0] S_MEM  = 3'd4;
    localparam logic [2:0] S_WB   = 3'd5;
    localparam logic [2:0] S_HALT = 3'd6;
    localparam logic [3:0] C_R    = 4'd0;
    localparam logic [3:0] C_IALU = 4'd1;
    localparam logic [3:0] C_LUI  = 4'd2;
    localparam logic [3:0] C_AUI  = 4'd3;
    localparam logic [3:0] C_LD   = 4'd4;
    localparam logic [3:0] C_ST   = 4'd5;
    localparam logic [3:0] C_BR   = 4'd6;
    localparam logic [3:0] C_JAL  = 4'd7;
    localparam logic [3:0] C_JALR = 4'd8;
    localparam logic [3:0] C_BAD  = 4'd15;

    logic [2:0]       state_q, state_d;
    logic [3:0]       cls_q, cls_d, cls_dec;
    logic [31:0]      boot_q, boot_d;
    logic [CNT_W-1:0] ret_q, ret_d;

    // opcode to instruction class; anything unlisted is illegal
    always_comb begin
        case (opcode)
            7'b0110011: cls_dec = C_R;
            7'b0010011: cls_dec = C_IALU;
            7'b0110111: cls_dec = C_LUI;
            7'b0010111: cls_dec = C_AUI;
            7'b0000011: cls_dec = C_LD;
            7'b0100011: cls_dec = C_ST;
            7'b1100011: cls_dec = C_BR;
            7'b1101111: cls_dec = C_JAL;
            7'b1100111: cls_dec = C_JALR;
            default:    cls_dec = C_BAD;
        endcase
    end

    // strobes decoded from current state, latched class, acks and branch result
    always_comb begin
        pc_en    = 1'b0;
        npc_sel  = 2'b00;
        ir_en    = 1'b0;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 2'b00;
        case (state_q)
            S_IF: begin
                imem_req = 1'b1;
                ir_en    = imem_ack;
            end
            S_EX: begin
                pc_en   = (cls_q == C_BR);
                npc_sel = (cls_q == C_BR && br_taken) ? 2'b01 : 2'b00;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == C_ST);
                pc_en    = dmem_ack && (cls_q == C_ST);
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_en   = 1'b1;
                wb_sel  = (cls_q == C_LD) ? 2'b01 :
                          (cls_q == C_JAL || cls_q == C_JALR) ? 2'b10 : 2'b00;
                npc_sel = (cls_q == C_JAL) ? 2'b01 : (cls_q == C_JALR) ? 2'b10 : 2'b00;
            end
            default: ;
        endcase
    end

    // next state; any commit overrides to IF, or HALT when a halt is requested
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        boot_d  = 32'd0;
        case (state_q)
            S_BOOT: begin
                if (boot_q >= 32'(HOLD - 1)) state_d = S_IF;
                else boot_d = boot_q + 32'd1;
            end
            S_IF:   state_d = imem_ack ? S_ID : S_IF;
            S_ID: begin
                cls_d   = (cls_dec == C_BAD) ? cls_q : cls_dec;
                state_d = (cls_dec == C_BAD) ? S_HALT : S_EX;
            end
            S_EX:   state_d = (cls_q == C_LD || cls_q == C_ST) ? S_MEM : S_WB;
            S_MEM:  state_d = dmem_ack ? S_WB : S_MEM;
            S_WB:   state_d = S_IF;
            S_HALT: state_d = S_HALT;
            default: state_d = S_BOOT;
        endcase
        if (pc_en) state_d = halt_req ? S_HALT : S_IF;
        ret_d = ret_q + {{(CNT_W-1){1'b0}}, pc_en};
    end

    // state registers with asynchronous reset back to BOOT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            cls_q   <= 4'd0;
            boot_q  <= 32'd0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            boot_q  <= boot_d;
            ret_q   <= ret_d;
        end
    end

    assign state   = state_q;
    assign retired = ret_q;
    assign halted  = (state_q == S_HALT);
endmodule
